// File: rtl/inst_fetch_bridge_pkg.sv
// Shared types and constants for the instruction fetch bridge and the icache that will replace it.
package inst_fetch_bridge_pkg;

    localparam int unsigned RESP_W       = 2;
    localparam int unsigned FETCH_ADDR_W = 32;

    // Read response codes on the R channel
    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'd0;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'd2;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'd3;

    // Fetch request payload as the icache will see it
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic                    uncache;
    } fetch_req_t;

endpackage

// File: rtl/inst_fetch_bridge_if.sv
// Signal bundle between the fetch stage / memory interconnect and the fetch bridge.
interface inst_fetch_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    // Fetch-stage request/response side
    logic                  icache_valid;
    logic [ADDR_WIDTH-1:0] inst_addr;
    logic                  inst_uncache_en;
    logic                  flush;
    logic                  inst_addr_ok;
    logic                  inst_data_ok;
    logic [DATA_WIDTH-1:0] inst_rdata;
    logic                  inst_fetch_err;
    logic                  icache_miss;

    // AR/R memory bus side
    logic                  ar_valid;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  ar_ready;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_ready;

    // Bridge view: responds to fetch requests, issues reads on the bus
    modport slave (
        input  icache_valid, inst_addr, inst_uncache_en, flush,
        input  ar_ready, r_valid, r_data, r_resp,
        output inst_addr_ok, inst_data_ok, inst_rdata, inst_fetch_err, icache_miss,
        output ar_valid, ar_addr, r_ready
    );

    // Environment view: fetch stage plus memory interconnect
    modport master (
        output icache_valid, inst_addr, inst_uncache_en, flush,
        output ar_ready, r_valid, r_data, r_resp,
        input  inst_addr_ok, inst_data_ok, inst_rdata, inst_fetch_err, icache_miss,
        input  ar_valid, ar_addr, r_ready
    );

endinterface

// File: rtl/inst_fetch_bridge.sv
// Uncached instruction fetch responder: turns fetch requests into single-word AR/R reads,
// keeps a bounded number in flight and drops responses that belong to flushed requests.
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_bridge_if.slave bus
);

    localparam int unsigned       CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [RESP_W-1:0] ERR_MASK = RESP_SLVERR & RESP_DECERR;

    logic                  r_ar_valid;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic [CNT_W-1:0]      r_out_cnt;
    logic [CNT_W-1:0]      r_cancel_cnt;
    logic                  r_data_ok;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_fetch_err;

    logic                  w_addr_ok;
    logic                  w_accept;
    logic                  w_ar_fire;
    logic                  w_r_fire;
    logic                  w_resp_err;
    logic                  w_deliver;
    logic [CNT_W-1:0]      w_out_after_r;
    logic [CNT_W-1:0]      w_out_nxt;
    logic [CNT_W-1:0]      w_cancel_nxt;
    logic                  w_unused;

    // Every request is served uncached and word aligned, so these inputs carry no information here
    assign w_unused = &{1'b0, bus.inst_uncache_en, bus.inst_addr[1:0]};

    assign w_addr_ok  = !bus.flush && !r_ar_valid && (r_out_cnt < MAX_CNT);
    assign w_accept   = bus.icache_valid && w_addr_ok;
    assign w_ar_fire  = r_ar_valid && bus.ar_ready;
    assign w_r_fire   = bus.r_valid;
    assign w_resp_err = (bus.r_resp & ERR_MASK) != RESP_OKAY;
    assign w_deliver  = w_r_fire && (r_cancel_cnt == '0) && !bus.flush;

    // In-flight count after this cycle's return; guarded so a stray response cannot wrap it
    assign w_out_after_r = (w_r_fire && (r_out_cnt != '0)) ? r_out_cnt - CNT_W'(1) : r_out_cnt;
    assign w_out_nxt     = w_out_after_r + CNT_W'(w_accept);

    // Flush reloads the drop count with everything still owed by the bus; otherwise drops consume it
    always_comb begin
        w_cancel_nxt = r_cancel_cnt;
        if (bus.flush) begin
            w_cancel_nxt = w_out_after_r;
        end else if (w_r_fire && (r_cancel_cnt != '0)) begin
            w_cancel_nxt = r_cancel_cnt - CNT_W'(1);
        end
    end

    // AR channel: load on accept, hold until the interconnect takes it (never retracted)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ar_valid <= 1'b0;
            r_ar_addr  <= '0;
        end else if (w_accept) begin
            r_ar_valid <= 1'b1;
            r_ar_addr  <= {bus.inst_addr[ADDR_WIDTH-1:2], 2'b00};
        end else if (w_ar_fire) begin
            r_ar_valid <= 1'b0;
        end
    end

    // Outstanding and to-be-dropped read counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_cnt    <= '0;
            r_cancel_cnt <= '0;
        end else begin
            r_out_cnt    <= w_out_nxt;
            r_cancel_cnt <= w_cancel_nxt;
        end
    end

    // Response to the fetch stage: one-cycle pulse, data zeroed on bus error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_ok   <= 1'b0;
            r_fetch_err <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_data_ok   <= w_deliver;
            r_fetch_err <= w_deliver && w_resp_err;
            if (w_deliver) begin
                r_rdata <= w_resp_err ? '0 : bus.r_data;
            end
        end
    end

    assign bus.inst_addr_ok   = w_addr_ok;
    assign bus.inst_data_ok   = r_data_ok;
    assign bus.inst_rdata     = r_rdata;
    assign bus.inst_fetch_err = r_fetch_err;
    assign bus.icache_miss    = r_out_cnt > r_cancel_cnt;
    assign bus.ar_valid       = r_ar_valid;
    assign bus.ar_addr        = r_ar_addr;
    assign bus.r_ready        = 1'b1;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: bench-side memory responder plus a transaction-level model
// (queue of accepted requests, each flagged when a flush cancels it) checked every cycle.
module tb_inst_fetch_bridge;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXO = 2;
    localparam int          BIG  = 1000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    inst_fetch_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        bit          cancelled;
    } txn_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    txn_t        q[$];      // accepted, not yet returned
    mem_t        mq[$];     // addresses the memory has taken, awaiting return
    logic [32:0] got[$];    // observed {err, rdata} pulses

    bit          exp_arv;
    logic [31:0] exp_ara;
    bit          exp_dok;
    bit          exp_err;
    logic [31:0] exp_rd;

    bit          req_v;
    logic [31:0] req_a;
    bit          do_flush;
    int          ar_pct;
    int          lat_min;
    int          lat_max;
    int          r_allow;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [1:0] memresp(input logic [31:0] a);
        case (a[6:4])
            3'd7:    return 2'd2;
            3'd6:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        q.delete();
        mq.delete();
        exp_arv = 1'b0;
        exp_ara = '0;
        exp_dok = 1'b0;
        exp_err = 1'b0;
        exp_rd  = '0;
    endtask

    // One clock: drive fetch + memory inputs, compare against the model, advance the model
    task automatic step();
        bit          exp_ok;
        bit          exp_miss;
        bit          rv;
        bit          arr;
        logic [1:0]  rr;
        mem_t        m;
        txn_t        h;
        @(negedge clk);
        cyc++;
        arr = ($urandom_range(99) < ar_pct);
        bus.ar_ready = arr;
        if (bus.ar_valid && arr) begin
            m.addr = bus.ar_addr;
            m.due  = cyc + int'($urandom_range(lat_max, lat_min));
            mq.push_back(m);
        end
        rv = (mq.size() != 0) && (r_allow > 0);
        if (rv) rv = (mq[0].due <= cyc);
        bus.r_valid = rv;
        if (rv) begin
            bus.r_data = memword(mq[0].addr);
            bus.r_resp = memresp(mq[0].addr);
            mq.delete(0);
            r_allow--;
        end else begin
            bus.r_data = $urandom;
            bus.r_resp = 2'($urandom);
        end
        bus.icache_valid    = req_v;
        bus.inst_addr       = req_a;
        bus.flush           = do_flush;
        bus.inst_uncache_en = 1'($urandom);
        #1;
        exp_ok   = !do_flush && !exp_arv && (q.size() < MAXO);
        exp_miss = 1'b0;
        foreach (q[i]) if (!q[i].cancelled) exp_miss = 1'b1;
        chk("addr_ok", 64'(bus.inst_addr_ok), 64'(exp_ok));
        chk("icache_miss", 64'(bus.icache_miss), 64'(exp_miss));
        chk("r_ready", 64'(bus.r_ready), 64'(1));
        chk("ar_valid", 64'(bus.ar_valid), 64'(exp_arv));
        if (exp_arv) chk("ar_addr", 64'(bus.ar_addr), 64'(exp_ara));
        chk("data_ok", 64'(bus.inst_data_ok), 64'(exp_dok));
        chk("fetch_err", 64'(bus.inst_fetch_err), 64'(exp_err));
        if (exp_dok) chk("rdata", 64'(bus.inst_rdata), 64'(exp_rd));
        if (bus.inst_data_ok) got.push_back({bus.inst_fetch_err, bus.inst_rdata});
        exp_dok = 1'b0;
        exp_err = 1'b0;
        if (rv && (q.size() != 0)) begin
            h = q.pop_front();
            if (!h.cancelled && !do_flush) begin
                rr      = memresp(h.addr);
                exp_dok = 1'b1;
                exp_err = (rr == 2'd2) || (rr == 2'd3);
                exp_rd  = exp_err ? 32'h0 : memword(h.addr);
            end
        end
        if (do_flush) foreach (q[i]) q[i].cancelled = 1'b1;
        if (req_v && exp_ok) begin
            h.addr      = {req_a[31:2], 2'b00};
            h.cancelled = 1'b0;
            q.push_back(h);
            exp_arv = 1'b1;
            exp_ara = h.addr;
        end else if (exp_arv && arr) begin
            exp_arv = 1'b0;
        end
    endtask

    // Asynchronous reset mid-cycle, check reset values, release on a falling edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        bus.flush = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_ar_valid", 64'(bus.ar_valid), 64'(0));
        chk("rst_ar_addr", 64'(bus.ar_addr), 64'(0));
        chk("rst_addr_ok", 64'(bus.inst_addr_ok), 64'(1));
        chk("rst_data_ok", 64'(bus.inst_data_ok), 64'(0));
        chk("rst_rdata", 64'(bus.inst_rdata), 64'(0));
        chk("rst_fetch_err", 64'(bus.inst_fetch_err), 64'(0));
        chk("rst_icache_miss", 64'(bus.icache_miss), 64'(0));
        chk("rst_r_ready", 64'(bus.r_ready), 64'(1));
        model_clear();
        got.delete();
        req_v = 1'b0;
        do_flush = 1'b0;
        bus.icache_valid = 1'b0;
        bus.r_valid = 1'b0;
        bus.ar_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue 0x1C000000 then 0x1C000004 and leave both waiting on the bus
    task automatic two_requests();
        req_v = 1'b1;
        req_a = 32'h1C00_0000;
        step();
        req_a = 32'h1C00_0004;
        repeat (3) step();
        req_v = 1'b0;
        step();
    endtask

    initial begin
        bus.icache_valid = 1'b0;
        bus.inst_addr = '0;
        bus.inst_uncache_en = 1'b0;
        bus.flush = 1'b0;
        bus.ar_ready = 1'b0;
        bus.r_valid = 1'b0;
        bus.r_data = '0;
        bus.r_resp = '0;
        req_v = 1'b0;
        req_a = '0;
        do_flush = 1'b0;
        ar_pct = 100;
        lat_min = 0;
        lat_max = 0;
        r_allow = BIG;
        model_clear();
        do_reset();

        // Single fetch, memory latency 3
        lat_min = 3;
        lat_max = 3;
        req_v = 1'b1;
        req_a = 32'h1C00_0000;
        step();
        req_v = 1'b0;
        step();
        chk("t1_ar_valid", 64'(bus.ar_valid), 64'(1));
        chk("t1_ar_addr", 64'(bus.ar_addr), 64'h1C00_0000);
        chk("t1_miss_set", 64'(bus.icache_miss), 64'(1));
        repeat (3) begin
            step();
            chk("t1_miss_hold", 64'(bus.icache_miss), 64'(1));
        end
        step();
        chk("t1_data_ok", 64'(bus.inst_data_ok), 64'(1));
        chk("t1_rdata", 64'(bus.inst_rdata), 64'h465A_5A5A);
        chk("t1_miss_clear", 64'(bus.icache_miss), 64'(0));
        repeat (3) step();
        chk("t1_one_pulse", 64'(got.size()), 64'(1));
        got.delete();

        // Two back-to-back requests, third blocked until the bus returns
        lat_min = 0;
        lat_max = 0;
        r_allow = 0;
        req_v = 1'b1;
        req_a = 32'h1C00_0000;
        step();
        req_a = 32'h1C00_0004;
        repeat (2) step();
        req_a = 32'h1C00_0008;
        step();
        repeat (4) begin
            step();
            chk("t2_third_blocked", 64'(bus.inst_addr_ok), 64'(0));
        end
        req_v = 1'b0;
        r_allow = BIG;
        repeat (6) step();
        chk("t2_count", 64'(got.size()), 64'(2));
        if (got.size() == 2) begin
            chk("t2_first", 64'(got[0]), {31'h0, 33'h0_465A_5A5A});
            chk("t2_second", 64'(got[1]), {31'h0, 33'h0_465A_5A5E});
        end
        got.delete();

        // Flush with two outstanding; both late returns are dropped
        r_allow = 0;
        two_requests();
        do_flush = 1'b1;
        step();
        do_flush = 1'b0;
        step();
        chk("t3_miss_after_flush", 64'(bus.icache_miss), 64'(0));
        r_allow = BIG;
        repeat (4) step();
        chk("t3_all_dropped", 64'(got.size()), 64'(0));
        req_v = 1'b1;
        req_a = 32'h1C00_0100;
        step();
        req_v = 1'b0;
        repeat (5) step();
        chk("t3_new_count", 64'(got.size()), 64'(1));
        if (got.size() == 1) chk("t3_new_word", 64'(got[0]), {31'h0, 33'h0_465A_5B5A});
        got.delete();

        // Flush in the same cycle as a return: one left to drop
        r_allow = 0;
        two_requests();
        r_allow = 1;
        do_flush = 1'b1;
        step();
        do_flush = 1'b0;
        step();
        chk("t4_suppressed", 64'(bus.inst_data_ok), 64'(0));
        chk("t4_miss", 64'(bus.icache_miss), 64'(0));
        req_v = 1'b1;
        req_a = 32'h1C00_0100;
        step();
        req_v = 1'b0;
        repeat (2) step();
        r_allow = BIG;
        repeat (6) step();
        chk("t4_count", 64'(got.size()), 64'(1));
        if (got.size() == 1) chk("t4_word", 64'(got[0]), {31'h0, 33'h0_465A_5B5A});
        got.delete();

        // Bus error response
        lat_min = 1;
        lat_max = 1;
        req_v = 1'b1;
        req_a = 32'h1C00_0070;
        step();
        req_v = 1'b0;
        repeat (6) step();
        chk("t5_count", 64'(got.size()), 64'(1));
        if (got.size() == 1) chk("t5_err_zero", 64'(got[0]), {31'h0, 33'h1_0000_0000});
        got.delete();

        // ar_ready held low, then reset mid-operation
        ar_pct = 0;
        req_v = 1'b1;
        req_a = 32'h1C00_0040;
        step();
        req_v = 1'b0;
        repeat (5) begin
            step();
            chk("t6_ar_valid_hold", 64'(bus.ar_valid), 64'(1));
            chk("t6_ar_addr_hold", 64'(bus.ar_addr), 64'h1C00_0040);
        end
        do_reset();

        // Randomized traffic with flushes and one mid-run reset
        ar_pct = 70;
        lat_min = 0;
        lat_max = 4;
        r_allow = BIG;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            req_v = ($urandom_range(99) < 60);
            req_a = 32'h1C00_0000 | ($urandom & 32'h0000_01FF);
            do_flush = ($urandom_range(99) < 4);
            step();
        end
        do_flush = 1'b0;
        req_v = 1'b0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
